// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
//   The only driver of the board LEDs. Shows one of four patterns (off, flowing
//   one-hot, blink, binary count) that advance by one step every TICK_CNT
//   unpaused clock cycles. A debounced mode_req pulse moves to the next mode and
//   loads that mode's starting pattern. The pause level freezes both the
//   prescaler and the pattern.
//
// Parameters
//   TICK_CNT  clock cycles per pattern step (>= 2)
//   LED_W     number of LEDs (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode_req   single-cycle request to advance the mode
//   pause      level; while high the prescaler and pattern hold
//   dir        FLOW direction: 0 rotates toward the MSB, 1 toward the LSB
//   led        registered LED drive, 1 = on
//   mode       current mode: 0 OFF, 1 FLOW, 2 BLINK, 3 COUNT
//   mode_ack   one-cycle pulse, mode_req was taken
//   step_tick  one-cycle pulse, first cycle a new stepped pattern is on led
//
// Mode FSM
//   state   | meaning
//   M_OFF   | led held at all zeros (steps still tick)
//   M_FLOW  | one-hot rotates one place per step, direction from dir
//   M_BLINK | led inverts each step, starts all ones
//   M_COUNT | led counts up modulo 2^LED_W, starts at zero
//   Every accepted mode_req moves to the next row and wraps from M_COUNT to M_OFF.
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter int TICK_CNT = 25_000_000,
  parameter int LED_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_req,
  input  logic             pause,
  input  logic             dir,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             mode_ack,
  output logic             step_tick
);

  localparam int CNT_W = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CNT - 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_FLOW  = 2'd1,
    M_BLINK = 2'd2,
    M_COUNT = 2'd3
  } mode_t;

  mode_t            mode_q, mode_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [LED_W-1:0] led_q, led_nxt;
  logic             ack_q, ack_nxt;
  logic             tick_q, tick_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_OFF;
      cnt_q  <= '0;
      led_q  <= '0;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      cnt_q  <= cnt_nxt;
      led_q  <= led_nxt;
      ack_q  <= ack_nxt;
      tick_q <= tick_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    cnt_nxt  = cnt_q;
    led_nxt  = led_q;
    ack_nxt  = 1'b0;
    tick_nxt = 1'b0;

    if (mode_req) begin
      // A request beats a coinciding wrap: the step that would have happened
      // on this edge is dropped and the new mode starts a full interval.
      mode_nxt = mode_t'(mode_q + 2'd1);
      cnt_nxt  = '0;
      ack_nxt  = 1'b1;
      unique case (mode_nxt)
        M_OFF:   led_nxt = '0;
        M_FLOW:  led_nxt = LED_W'(1);
        M_BLINK: led_nxt = '1;
        M_COUNT: led_nxt = '0;
        default: led_nxt = '0;
      endcase
    end else if (!pause) begin
      if (cnt_q == CNT_MAX) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        unique case (mode_q)
          M_OFF:   led_nxt = '0;
          M_FLOW:  led_nxt = dir ? {led_q[0], led_q[LED_W-1:1]}
                                 : {led_q[LED_W-2:0], led_q[LED_W-1]};
          M_BLINK: led_nxt = ~led_q;
          M_COUNT: led_nxt = led_q + LED_W'(1);
          default: led_nxt = '0;
        endcase
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign mode_ack  = ack_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

  localparam int TICK = 4;
  localparam int W    = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode_req = 1'b0;
  logic         pause = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] led;
  logic [1:0]   mode;
  logic         mode_ack;
  logic         step_tick;

  led_seq_ctrl #(.TICK_CNT(TICK), .LED_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .pause(pause), .dir(dir),
    .led(led), .mode(mode), .mode_ack(mode_ack), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic [1:0]   mode;
    logic         ack;
    logic         tick;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: "left" counts cycles remaining until the next step.
  int m_mode;
  int m_led;
  int m_left;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_led  = 0;
    m_left = TICK;
  endtask

  // Drive one cycle of inputs (called at negedge+1), predict the outputs that
  // appear after the coming rising edge, and return at the following negedge+1.
  task automatic cyc(input logic req, input logic p);
    exp_t e;
    int mask;
    mask = (1 << W) - 1;
    mode_req = req;
    pause    = p;
    e.ack  = 1'b0;
    e.tick = 1'b0;
    if (req) begin
      m_mode = (m_mode + 1) % 4;
      m_left = TICK;
      e.ack  = 1'b1;
      case (m_mode)
        1:       m_led = 1;
        2:       m_led = mask;
        default: m_led = 0;
      endcase
    end else if (!p) begin
      m_left--;
      if (m_left == 0) begin
        m_left = TICK;
        e.tick = 1'b1;
        case (m_mode)
          1: m_led = dir ? (((m_led >> 1) | (m_led << (W - 1))) & mask)
                         : (((m_led << 1) | (m_led >> (W - 1))) & mask);
          2: m_led = (~m_led) & mask;
          3: m_led = (m_led + 1) & mask;
          default: m_led = 0;
        endcase
      end
    end
    e.led  = W'(m_led);
    e.mode = 2'(m_mode);
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic p);
    for (int i = 0; i < n; i++) cyc(1'b0, p);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("led",       8'(led),       8'(e.led));
      check("mode",      8'(mode),      8'(e.mode));
      check("mode_ack",  8'(mode_ack),  8'(e.ack));
      check("step_tick", 8'(step_tick), 8'(e.tick));
    end
  end

  initial begin
    // Reset held for 200 ns
    model_reset();
    #200;
    check("rst_led",  8'(led),       8'h00);
    check("rst_mode", 8'(mode),      8'h00);
    check("rst_ack",  8'(mode_ack),  8'h00);
    check("rst_tick", 8'(step_tick), 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // OFF: ticks every 4 cycles, led stays 00
    run(12, 1'b0);

    // FLOW
    cyc(1'b1, 1'b0);
    check("flow_entry_led",  8'(led),      8'h01);
    check("flow_entry_mode", 8'(mode),     8'h01);
    check("flow_entry_ack",  8'(mode_ack), 8'h01);
    dir = 1'b0;
    run(8, 1'b0);
    run(2, 1'b0);
    dir = 1'b1;
    run(6, 1'b0);

    // Pause for 7 cycles mid-interval
    run(1, 1'b0);
    run(7, 1'b1);
    run(8, 1'b0);

    // mode_req during pause: BLINK loads and holds
    run(2, 1'b1);
    cyc(1'b1, 1'b1);
    check("pause_req_led",  8'(led),  8'h03);
    check("pause_req_mode", 8'(mode), 8'h02);
    run(3, 1'b1);

    // BLINK, then COUNT, then wrap to OFF
    run(8, 1'b0);
    cyc(1'b1, 1'b0);
    run(16, 1'b0);
    cyc(1'b1, 1'b0);
    check("wrap_off_led",  8'(led),  8'h00);
    check("wrap_off_mode", 8'(mode), 8'h00);
    run(4, 1'b0);

    // Collision: request on the cycle the prescaler sits at TICK-1
    cyc(1'b1, 1'b0);
    run(2, 1'b0);
    while (m_left != 1) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("collide_tick", 8'(step_tick), 8'h00);
    check("collide_mode", 8'(mode),      8'h02);
    run(5, 1'b0);

    // COUNT with a nonzero led, then asynchronous reset between edges
    cyc(1'b1, 1'b0);
    run(5, 1'b0);
    check("pre_async_led", 8'(led), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led",  8'(led),       8'h00);
    check("async_mode", 8'(mode),      8'h00);
    check("async_ack",  8'(mode_ack),  8'h00);
    check("async_tick", 8'(step_tick), 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(5, 1'b0);

    // Back-to-back requests from OFF
    cyc(1'b1, 1'b0);
    check("b2b_mode1", 8'(mode), 8'h01);
    cyc(1'b1, 1'b0);
    check("b2b_mode2", 8'(mode), 8'h02);
    cyc(1'b1, 1'b0);
    check("b2b_mode3", 8'(mode), 8'h03);
    check("b2b_led",   8'(led),  8'h00);
    check("b2b_ack",   8'(mode_ack), 8'h01);
    run(4, 1'b0);

    @(posedge clk);
    #2;
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED sequencing controller that owns the board LED outputs and drives them with one of four patterns: off, flowing one-hot, blink, and binary count. A prescaler sets the step rate. A pulse request advances the mode, and a level input pauses the sequence. The block sits between debounced key logic and the LED pins, and supersedes free-running flow logic as the single driver of `led`.

## Interface
Parameters:
- `TICK_CNT`, default 25_000_000: clock cycles per pattern step. Legal range is ≥ 2. The counter width is $clog2(TICK_CNT).
- `LED_W`, default 2: number of LEDs. Legal range is ≥ 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `mode_req`, input, 1: single-cycle pulse that advances the mode. Synchronous and already debounced.
- `pause`, input, 1: level. While high, the prescaler and pattern hold.
- `dir`, input, 1: FLOW direction. 0 rotates toward the MSB, 1 rotates toward the LSB. Sampled at each step.
- `led`, output, LED_W: registered LED drive, 1 = on.
- `mode`, output, 2: current mode. 0 = OFF, 1 = FLOW, 2 = BLINK, 3 = COUNT.
- `mode_ack`, output, 1: one-cycle pulse confirming that `mode_req` was taken.
- `step_tick`, output, 1: one-cycle pulse, high in the first cycle that a new stepped pattern is visible on `led`.

## Operation
- Reset (asynchronous, while `rst_n` is 0) forces `mode`=0, `led`=0, prescaler=0, `mode_ack`=0 and `step_tick`=0.
- Prescaler:
  - Each edge with `pause`=0 and no `mode_req`: counter increments.
  - At `TICK_CNT`-1 it wraps to 0 and a step occurs on that same edge.
  - With `pause`=1 the counter holds.
- Step, by mode (all registered, so the new value appears after the step edge):
  - OFF: `led` stays all 0s.
  - FLOW: `led` rotates by one position. With `dir`=0, the MSB wraps to the LSB. With `dir`=1, the LSB wraps to the MSB.
  - BLINK: `led` is bitwise inverted.
  - COUNT: `led` increments modulo 2^LED_W, so all 1s wraps to 0.
- `step_tick` goes to 1 on every step edge in every mode, OFF included. It returns to 0 on the next edge.
- Mode request. `mode_req` sampled high causes the following on the next edge:
  - `mode` becomes `mode`+1, wrapping 3→0.
  - The prescaler clears to 0.
  - `led` loads the initial value of the new mode: OFF = 0, FLOW = LSB only, BLINK = all 1s, COUNT = 0.
  - `mode_ack` goes to 1 for one cycle.
- Simultaneous events:
  - `mode_req` on the same edge the prescaler would wrap: the mode change wins. No step occurs and `step_tick` stays 0.
  - `mode_req` while `pause`=1: it is honoured. The mode changes and the initial pattern loads, then holds until `pause` falls.
  - Back-to-back `mode_req` pulses: each is accepted, one mode advance per cycle.
- A `dir` change takes effect at the next step only. It causes no immediate `led` change.
- Reset asserted mid-sequence clears the block immediately, without waiting for a clock. On release the block restarts in OFF with the prescaler at 0.

## Timing
- `mode_req` to `mode`/`led`/`mode_ack`: 1 cycle of latency.
- Step period: exactly `TICK_CNT` unpaused cycles between consecutive `step_tick` pulses.
- First step after reset release, or after any accepted `mode_req`: on the `TICK_CNT`-th subsequent unpaused rising edge.
- A pause lasting P cycles delays the next step by exactly P cycles.
- `led`, `mode`, `mode_ack` and `step_tick` are all flop outputs, with no combinational path from inputs.

## Test plan
All scenarios use `TICK_CNT`=4 and `LED_W`=2.
- **Reset.** Hold `rst_n`=0 for 200 ns, then release. Required: `led`=00, `mode`=0 and `step_tick` pulsing every 4 cycles; `led` stays 00. Assert `rst_n` asynchronously between edges: outputs clear before the next edge.
- **FLOW rotation.** One `mode_req` pulse. Required: next cycle `mode`=1, `led`=01, `mode_ack`=1. With `dir`=0, `led` steps 01→10→01 every 4 cycles. Switch to `dir`=1 mid-interval: the next step still rotates correctly and there is no early change.
- **BLINK and COUNT.** Advance to mode 2. Required: `led`=11→00→11 every 4 cycles. Advance to mode 3. Required: `led`=00→01→10→11→00. One more `mode_req` wraps to mode 0 with `led`=00.
- **Pause.** In FLOW, raise `pause` for 7 cycles mid-interval. Required: `led` holds, and the next `step_tick` arrives exactly 7 cycles later than unpaused. `mode_req` during the pause loads the next mode's initial pattern and `mode_ack` pulses.
- **Collision.** Assert `mode_req` on the cycle the counter equals 3. Required: mode advances, `step_tick` stays 0, and the next step comes 4 cycles later.
- **Back-to-back requests.** Three consecutive `mode_req` cycles starting from mode 0. Required: `mode` reads 1, 2, 3 on successive cycles, with 3 `mode_ack` pulses and `led`=00 at the end.
